// File: rtl/demux1to2_fifo.sv
// ============================================================================
// Module      : demux1to2_fifo
// Description : One input stream steered to two independent output FIFOs,
//               either by in_sel or by an alternating round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sel,
    input  logic                     auto,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             dest;
    logic             push_en;
    logic             rr_ptr_q;
    logic             rr_ptr_d;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [CW-1:0]    count [2];
    logic [WIDTH-1:0] head  [2];

    assign out_ready = {out1_ready, out0_ready};
    assign dest      = auto ? rr_ptr_q : in_sel;
    // Counts clear asynchronously, so in_ready is already 1 during reset.
    assign in_ready  = ~full[dest];
    assign push_en   = in_valid & in_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q ^ (push_en & auto);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_ch
            logic [AW-1:0]    wr_ptr_q;
            logic [AW-1:0]    wr_ptr_d;
            logic [AW-1:0]    rd_ptr_q;
            logic [AW-1:0]    rd_ptr_d;
            logic [CW-1:0]    count_q;
            logic [CW-1:0]    count_d;
            logic [WIDTH-1:0] mem_q [DEPTH];

            assign push[ch]      = push_en & (dest == 1'(ch));
            assign pop[ch]       = out_ready[ch] & (count_q != '0);
            assign full[ch]      = (count_q == CW'(DEPTH));
            assign out_valid[ch] = (count_q != '0);
            assign count[ch]     = count_q;
            // Storage is not reset; masking keeps the head at zero while empty.
            assign head[ch]      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

            always_comb begin
                wr_ptr_d = wr_ptr_q + AW'(push[ch]);
                rd_ptr_d = rd_ptr_q + AW'(pop[ch]);
                count_d  = count_q + CW'(push[ch]) - CW'(pop[ch]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push[ch]) begin
                    mem_q[wr_ptr_q] <= in_data;
                end
            end
        end
    endgenerate

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign out0_count = count[0];
    assign out1_count = count[1];

endmodule

`default_nettype wire

// File: tb/tb_demux1to2_fifo.sv
// ============================================================================
// Module      : tb_demux1to2_fifo
// Description : Self-checking bench for demux1to2_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1to2_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic             auto_i;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [2:0]       out0_count;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [2:0]       out1_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    bit               rr;

    always #5 clk = ~clk;

    demux1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .auto       (auto_i),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    function automatic int qsize(input bit ch);
        return ch ? q1.size() : q0.size();
    endfunction

    function automatic bit model_in_ready();
        bit d;
        d = auto_i ? rr : in_sel;
        return qsize(d) < DEPTH;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        rr = 1'b0;
    endtask

    task automatic drive(input bit v, input bit s, input bit a,
                         input logic [WIDTH-1:0] d, input bit r0, input bit r1);
        in_valid   = v;
        in_sel     = s;
        auto_i     = a;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Advance one clock and apply the same transfer rules to the queue model.
    task automatic tick();
        bit               dst;
        bit               do_push;
        bit               p0;
        bit               p1;
        logic [WIDTH-1:0] d;
        dst     = auto_i ? rr : in_sel;
        do_push = in_valid && (qsize(dst) < DEPTH) && rst_n;
        p0      = out0_ready && (q0.size() > 0);
        p1      = out1_ready && (q1.size() > 0);
        d       = in_data;
        @(posedge clk);
        if (rst_n) begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (do_push) begin
                if (dst) q1.push_back(d);
                else     q0.push_back(d);
                if (auto_i) rr = ~rr;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 0, 8'hFF, 1, 1);
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b want 00", out1_valid, out0_valid);
        end
        checks++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h/%h want 00/00", out0_data, out1_data);
        end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (out0_count !== 3'd0 || out1_count !== 3'd0) begin
            errors++; $display("FAIL reset_no_push got %0d/%0d want 0/0", out0_count, out1_count);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'h11 * (i + 1));
            drive(1, 0, 0, e, 0, 0);
            tick();
        end
        drive(0, 0, 0, 8'h00, 0, 0);
        #1;
        checks++;
        if (out0_count !== 3'd4) begin
            errors++; $display("FAIL fill_count got %0d want 4", out0_count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ready_sel0 got %b want 0", in_ready);
        end
        checks++;
        if (out1_valid !== 1'b0) begin
            errors++; $display("FAIL fill_out1_valid got %b want 0", out1_valid);
        end
        in_sel = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_ready_sel1 got %b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'h11 * (i + 1));
            drive(0, 0, 0, 8'h00, 1, 0);
            #1;
            checks++;
            if (out0_valid !== 1'b1 || out0_data !== e) begin
                errors++; $display("FAIL fill_drain[%0d] got %b/%h want 1/%h", i, out0_valid, out0_data, e);
            end
            tick();
        end
        drive(0, 0, 0, 8'h00, 1, 0);
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out0_count !== 3'd0) begin
            errors++; $display("FAIL fill_empty got %b/%0d want 0/0", out0_valid, out0_count);
        end
        tick();
    endtask

    task automatic test_round_robin();
        bit               prev_ch = 1'b0;
        logic [WIDTH-1:0] prev_d  = '0;
        logic [WIDTH-1:0] d;
        bit               vo;
        logic [WIDTH-1:0] dout;
        for (int i = 0; i <= 6; i++) begin
            d = 8'(8'hA0 + i);
            if (i < 6) drive(1, 0, 1, d, 1, 1);
            else       drive(0, 0, 1, 8'h00, 1, 1);
            #1;
            if (i > 0) begin
                vo   = prev_ch ? out1_valid : out0_valid;
                dout = prev_ch ? out1_data  : out0_data;
                checks++;
                if (vo !== 1'b1 || dout !== prev_d) begin
                    errors++; $display("FAIL rr_word[%0d] ch%0d got %b/%h want 1/%h", i - 1, prev_ch, vo, dout, prev_d);
                end
            end
            if (i < 6) begin
                vo = rr ? out1_valid : out0_valid;
                checks++;
                if (vo !== 1'b0 || rr !== bit'(i % 2)) begin
                    errors++; $display("FAIL rr_latency[%0d] got valid %b ch %0d want valid 0 ch %0d", i, vo, rr, i % 2);
                end
                prev_ch = rr;
                prev_d  = d;
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 0, 8'hB1, 0, 0); tick();
        drive(1, 1, 0, 8'hB2, 0, 0); tick();
        drive(1, 1, 0, 8'h5A, 0, 1);
        #1;
        checks++;
        if (out1_count !== 3'd2 || out1_data !== 8'hB1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL simul_pre got %0d/%h/%b want 2/b1/1", out1_count, out1_data, in_ready);
        end
        tick();
        drive(0, 1, 0, 8'h00, 0, 1);
        #1;
        checks++;
        if (out1_count !== 3'd2) begin
            errors++; $display("FAIL simul_count got %0d want 2", out1_count);
        end
        checks++;
        if (out1_data !== 8'hB2) begin
            errors++; $display("FAIL simul_pop1 got %h want b2", out1_data);
        end
        tick();
        #1;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h5A) begin
            errors++; $display("FAIL simul_pop2 got %b/%h want 1/5a", out1_valid, out1_data);
        end
        tick();
        #1;
        checks++;
        if (out1_count !== 3'd0) begin
            errors++; $display("FAIL simul_empty got %0d want 0", out1_count);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] src [10];
        int               sent = 0;
        int               rcv  = 0;
        int               cyc  = 0;
        for (int i = 0; i < 10; i++) src[i] = 8'($urandom);
        while (rcv < 10 && cyc < 200) begin
            drive(sent < 10, 0, 0, (sent < 10) ? src[sent] : 8'h00, cyc[0], 0);
            #1;
            checks++;
            if (out0_count > 3'd4 || int'(out0_count) != q0.size()) begin
                errors++; $display("FAIL wrap_count got %0d want %0d", out0_count, q0.size());
            end
            if (out0_valid && out0_ready) begin
                checks++;
                if (out0_data !== src[rcv]) begin
                    errors++; $display("FAIL wrap_order[%0d] got %h want %h", rcv, out0_data, src[rcv]);
                end
                rcv++;
            end
            if (in_valid && model_in_ready()) sent++;
            tick();
            cyc++;
        end
        checks++;
        if (rcv != 10) begin
            errors++; $display("FAIL wrap_timeout got %0d words want 10", rcv);
        end
        drive(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 8'h31, 0, 0); tick();
        drive(1, 0, 0, 8'h32, 0, 0); tick();
        drive(1, 0, 0, 8'h33, 0, 0); tick();
        drive(0, 0, 0, 8'h00, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out0_count !== 3'd0 || out0_data !== 8'h00) begin
            errors++; $display("FAIL async_reset got %b/%0d/%h want 0/0/00", out0_valid, out0_count, out0_data);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 8'h77, 0, 0);
        tick();
        drive(0, 0, 0, 8'h00, 0, 0);
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h77 || out0_count !== 3'd1) begin
            errors++; $display("FAIL post_reset_push got %b/%h/%0d want 1/77/1", out0_valid, out0_data, out0_count);
        end
        drive(0, 0, 0, 8'h00, 1, 0);
        tick();
    endtask

    task automatic test_rr_resume();
        drive(1, 0, 1, 8'hC0, 0, 0); tick();
        drive(1, 0, 0, 8'hC1, 0, 0); tick();
        drive(1, 0, 0, 8'hC2, 0, 0); tick();
        drive(1, 0, 1, 8'hC3, 0, 0); tick();
        drive(0, 0, 0, 8'h00, 0, 0);
        #1;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'hC3) begin
            errors++; $display("FAIL rr_resume_ch1 got %b/%h want 1/c3", out1_valid, out1_data);
        end
        checks++;
        if (out0_count !== 3'd3 || out0_data !== 8'hC0) begin
            errors++; $display("FAIL rr_resume_ch0 got %0d/%h want 3/c0", out0_count, out0_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 8'h00, 1, 1);
            tick();
        end
    endtask

    task automatic test_random();
        bit a = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                model_reset();
            end
            if ($urandom_range(0, 7) == 0) a = ~a;
            drive($urandom_range(0, 3) != 0, 1'($urandom), a, 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (in_ready !== model_in_ready()) begin
                errors++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, model_in_ready());
            end
            checks++;
            if (int'(out0_count) != q0.size() || out0_valid !== (q0.size() > 0)) begin
                errors++; $display("FAIL rand_ch0_state[%0d] got %0d/%b want %0d", i, out0_count, out0_valid, q0.size());
            end
            checks++;
            if (int'(out1_count) != q1.size() || out1_valid !== (q1.size() > 0)) begin
                errors++; $display("FAIL rand_ch1_state[%0d] got %0d/%b want %0d", i, out1_count, out1_valid, q1.size());
            end
            if (q0.size() > 0) begin
                checks++;
                if (out0_data !== q0[0]) begin
                    errors++; $display("FAIL rand_ch0_data[%0d] got %h want %h", i, out0_data, q0[0]);
                end
            end
            if (q1.size() > 0) begin
                checks++;
                if (out1_data !== q1[0]) begin
                    errors++; $display("FAIL rand_ch1_data[%0d] got %h want %h", i, out1_data, q1[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_round_robin();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        test_rr_resume();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
